// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
//   Two-requester APB master. Commands posted on req_* are granted round-robin
//   and run through the APB SETUP/ACCESS sequence with wait-state support. An
//   ACCESS phase that never sees pready is aborted after TIMEOUT cycles. Every
//   accepted command gets exactly one single-cycle completion on rsp_valid.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/write [1:0] per-requester command valid / direction (1 = write)
//   req_addr, req_wdata   packed per-requester fields, requester i at
//                         [i*W +: W]
//   req_ack [1:0]         one-cycle pulse: command of requester i accepted
//   rsp_valid [1:0]       one-cycle pulse: command of requester i completed
//   rsp_rdata, rsp_err    completion data / error, held between responses
//   busy                  high while a transfer is in SETUP or ACCESS
//   psel..pslverr         APB master port
// -----------------------------------------------------------------------------
module apb_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ack,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  // Wait counter only has to reach TIMEOUT-1; keep at least one bit so the
  // design still elaborates with the timeout disabled.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic              rr;        // favoured requester on a tie
  logic              owner;     // requester of the transfer in flight
  logic [CNT_W-1:0]  wait_cnt;

  logic              winner;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_write;
  logic              timeout_hit;
  logic              done;

  // Arbitration: on a tie rr wins, otherwise the single valid requester.
  // With only bit 0 set, req_valid[1] is 0, which selects requester 0.
  always_comb begin
    winner    = (&req_valid) ? rr : req_valid[1];
    win_addr  = winner ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
    win_wdata = winner ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    win_write = req_write[winner];
  end

  // A ready slave in the final allowed cycle completes normally, so the abort
  // only applies when pready is low.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST_WAIT);
  assign done        = pready || timeout_hit;

  // NOTE: every register here updates with <= so all of them see the values
  // from before the edge; a blocking = would let later statements observe
  // half-updated state and break the registered-output timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      owner     <= 1'b0;
      wait_cnt  <= '0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      // Handshake outputs are single-cycle pulses.
      req_ack   <= '0;
      rsp_valid <= '0;

      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            owner           <= winner;
            rr              <= ~winner;
            paddr           <= win_addr;
            pwrite          <= win_write;
            pwdata          <= win_write ? win_wdata : '0;
            psel            <= 1'b1;
            penable         <= 1'b0;
            busy            <= 1'b1;
            wait_cnt        <= '0;
            req_ack[winner] <= 1'b1;
            state           <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (done) begin
            psel             <= 1'b0;
            penable          <= 1'b0;
            busy             <= 1'b0;
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= (pready && !pwrite) ? prdata : '0;
            rsp_err          <= pready ? pslverr : 1'b1;
            state            <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_arbiter
//   Randomised and directed stimulus for apb_arbiter. The stimulus side keeps
//   its own round-robin pointer and, for every command it posts, pushes the
//   expected transfer (requester, APB fields, ACCESS length, response) into a
//   scoreboard queue plus a slave behaviour plan. A monitor pops and compares
//   as the DUT presents SETUP phases and responses; a slave model drives
//   pready/prdata/pslverr from the plan.
// -----------------------------------------------------------------------------
module tb_apb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          waits;    // pready=0 cycles before the slave answers
    logic [31:0] prdata;
    bit          slverr;
  } plan_t;

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;    // expected pwdata (0 for reads)
    logic [31:0] rdata;
    bit          err;
    int          len;      // expected ACCESS cycles
    bit          queued;   // command was already waiting at the previous rsp
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_write = '0;
  logic [2*AW-1:0] req_addr  = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ack, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, busy, psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata  = '0;
  logic            pready  = 1'b0;
  logic            pslverr = 1'b0;

  apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int    n_cmp  = 0;
  int    n_fail = 0;
  exp_t  exp_q[$];
  plan_t plan_q[$];
  cmd_t  cmd[2];
  plan_t pln[2];
  bit    rr_m   = 1'b0;   // reference round-robin pointer
  bit    b2b    = 1'b0;   // next grant follows a response with no gap
  bit    mon_en = 1'b1;
  int    cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of a command from the slave plan: answered within
  // TIMEOUT cycles -> normal completion, otherwise an error abort.
  function automatic exp_t expect_of(input bit g);
    exp_t e;
    e.req    = g;
    e.addr   = cmd[g].addr;
    e.wr     = cmd[g].wr;
    e.wdata  = cmd[g].wr ? cmd[g].wdata : 32'h0;
    e.queued = 1'b0;
    if (pln[g].waits < TO) begin
      e.len   = pln[g].waits + 1;
      e.err   = pln[g].slverr;
      e.rdata = cmd[g].wr ? 32'h0 : pln[g].prdata;
    end else begin
      e.len   = TO;
      e.err   = 1'b1;
      e.rdata = 32'h0;
    end
    return e;
  endfunction

  // Post a command pattern (bit i = requester i) and hold each requester
  // until its ack. Returns without waiting for completion.
  task automatic issue(input bit [1:0] pat);
    bit   order[2];
    int   n;
    int   iters = 0;
    bit   first_seen = 1'b0;
    bit [1:0] pend;
    exp_t e;
    n        = (pat == 2'b11) ? 2 : 1;
    order[0] = (pat == 2'b11) ? rr_m : pat[1];
    order[1] = ~order[0];
    for (int k = 0; k < n; k++) begin
      e        = expect_of(order[k]);
      e.queued = b2b || (k == 1);
      exp_q.push_back(e);
      plan_q.push_back(pln[order[k]]);
      rr_m = ~order[k];
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      if (pat[g]) begin
        req_write[g]         = cmd[g].wr;
        req_addr[g*AW +: AW] = cmd[g].addr;
        req_wdata[g*DW +: DW] = cmd[g].wdata;
      end
    end
    req_valid = pat;
    pend      = pat;
    while (pend != 2'b00 && iters < 300) begin
      @(negedge clk);
      iters++;
      if ((req_ack & pend) != 2'b00) begin
        if (!b2b && !first_seen) check("ack_latency", 64'(iters), 64'd1);
        first_seen = 1'b1;
      end
      pend      = pend & ~req_ack;
      req_valid = pend;
    end
    if (pend != 2'b00) check("ack_timeout", 64'(pend), 64'd0);
    b2b = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'((exp_q.size() == 0) && !busy), 64'd1);
    @(negedge clk);
    b2b = 1'b0;
  endtask

  function automatic int pick_waits();
    int r = $urandom_range(0, 9);
    if (r < 6) return r;
    if (r == 6) return TO - 1;
    if (r == 7) return TO;
    return TO + 4;
  endfunction

  task automatic rand_cmds();
    for (int g = 0; g < 2; g++) begin
      cmd[g].wr     = 1'($urandom);
      cmd[g].addr   = $urandom & 32'hFFFF_FFFC;
      cmd[g].wdata  = $urandom;
      pln[g].waits  = pick_waits();
      pln[g].prdata = $urandom;
      pln[g].slverr = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Slave model: answers each ACCESS after plan.waits low-ready cycles and
  // drives noise on the data/error lines whenever it is not answering.
  initial begin
    plan_t cur;
    int    acc;
    cur.waits = 0; cur.prdata = '0; cur.slverr = 1'b0;
    acc = 0;
    forever begin
      @(negedge clk);
      if (psel && !penable) begin
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        acc     = 0;
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end else if (psel && penable) begin
        acc++;
        if (acc > cur.waits) begin
          pready  = 1'b1;
          prdata  = cur.prdata;
          pslverr = cur.slverr;
        end else begin
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = 1'($urandom);
        end
      end else begin
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t cur;
    int   acc = 0;
    int   setup_cyc = 0;
    int   last_rsp = -10;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (psel && !penable) begin
          if (exp_q.size() == 0) begin
            check("unexpected_setup", 64'(psel), 64'd0);
          end else begin
            cur       = exp_q.pop_front();
            acc       = 0;
            setup_cyc = cyc;
            check("setup_ack",    64'(req_ack), 64'(2'b01 << cur.req));
            check("setup_paddr",  64'(paddr),   64'(cur.addr));
            check("setup_pwrite", 64'(pwrite),  64'(cur.wr));
            check("setup_pwdata", 64'(pwdata),  64'(cur.wdata));
            check("setup_busy",   64'(busy),    64'd1);
            if (cur.queued) check("b2b_gap", 64'(cyc), 64'(last_rsp + 1));
          end
        end else if (psel && penable) begin
          acc++;
        end
        if (rsp_valid != 2'b00) begin
          check("rsp_valid",  64'(rsp_valid), 64'(2'b01 << cur.req));
          check("rsp_rdata",  64'(rsp_rdata), 64'(cur.rdata));
          check("rsp_err",    64'(rsp_err),   64'(cur.err));
          check("access_len", 64'(acc),       64'(cur.len));
          check("rsp_cycle",  64'(cyc),       64'(setup_cyc + 1 + cur.len));
          check("rsp_psel",   64'({psel, penable, busy}), 64'd0);
          last_rsp = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #3 rst = 1'b1;
    #2;
    check("reset_ctrl", 64'({psel, penable, pwrite, busy, req_ack, rsp_valid, rsp_err}), 64'd0);
    check("reset_data", 64'({paddr, pwdata}), 64'd0);
    check("reset_rdata", 64'(rsp_rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin from reset: both valid, four commands each.
    for (int i = 0; i < 4; i++) begin
      rand_cmds();
      pln[0].waits = $urandom_range(0, 2);
      pln[1].waits = $urandom_range(0, 2);
      issue(2'b11);
    end
    drain();

    // Single write, zero wait.
    cmd[0] = '{wr: 1'b1, addr: 32'h1000, wdata: 32'hA5A5_A5A5};
    pln[0] = '{waits: 0, prdata: 32'h1234_5678, slverr: 1'b0};
    issue(2'b01);
    drain();

    // Read with three wait states.
    cmd[1] = '{wr: 1'b0, addr: 32'h2004, wdata: 32'h5555_5555};
    pln[1] = '{waits: 3, prdata: 32'hDEAD_BEEF, slverr: 1'b0};
    issue(2'b10);
    drain();

    // Timeout on the favoured requester, the other queued behind it.
    rand_cmds();
    pln[rr_m]  = '{waits: TO + 10, prdata: 32'hFFFF_FFFF, slverr: 1'b0};
    pln[~rr_m] = '{waits: 0, prdata: 32'h0BAD_CAFE, slverr: 1'b0};
    issue(2'b11);
    drain();

    // Slave error with ready, then ready in the final allowed cycle.
    rand_cmds();
    pln[0] = '{waits: 1, prdata: 32'h1111_2222, slverr: 1'b1};
    issue(2'b01);
    drain();
    rand_cmds();
    cmd[1].wr = 1'b0;
    pln[1] = '{waits: TO - 1, prdata: 32'hCAFE_F00D, slverr: 1'b0};
    issue(2'b10);
    drain();

    // Random back-to-back traffic.
    for (int i = 0; i < 30; i++) begin
      rand_cmds();
      issue(2'($urandom_range(1, 3)));
    end
    drain();

    // Reset in the second ACCESS cycle: requester 0 granted so rr would be 1.
    mon_en = 1'b0;
    cmd[0] = '{wr: 1'b0, addr: 32'h3000, wdata: 32'h0};
    pln[0] = '{waits: TO + 4, prdata: 32'h0, slverr: 1'b0};
    plan_q.push_back(pln[0]);
    @(negedge clk);
    req_addr[0 +: AW] = cmd[0].addr;
    req_write[0]      = 1'b0;
    req_valid         = 2'b01;
    @(negedge clk);
    check("rst_test_ack", 64'({req_ack, psel, penable}), 64'({2'b01, 1'b1, 1'b0}));
    req_valid = 2'b00;
    @(negedge clk);
    check("rst_test_access", 64'({psel, penable}), 64'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_abort_ctrl", 64'({psel, penable, pwrite, busy, req_ack, rsp_valid, rsp_err}), 64'd0);
    check("rst_abort_data", 64'({paddr, pwdata}), 64'd0);
    check("rst_abort_rdata", 64'(rsp_rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    plan_q.delete();
    exp_q.delete();
    rr_m   = 1'b0;
    b2b    = 1'b0;
    mon_en = 1'b1;
    rand_cmds();
    pln[0].waits = 1;
    pln[1].waits = 0;
    issue(2'b11);
    drain();

    // A few more random commands after the reset.
    for (int i = 0; i < 6; i++) begin
      rand_cmds();
      issue(2'($urandom_range(1, 3)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
